// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: turns EX/MEM load/store requests into a
// req/ack bus transaction, stalls the pipeline meanwhile and flags bad or timed-out accesses.
module mem_access_ctrl #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memrdin,
  input  logic              memwrin,
  input  logic [AWIDTH-1:0] addrin,
  input  logic [DWIDTH-1:0] wdatain,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [AWIDTH-1:0] dmem_addr,
  output logic [DWIDTH-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DWIDTH-1:0] dmem_rdata,
  output logic              stall,
  output logic [DWIDTH-1:0] rdataout,
  output logic              misalign,
  output logic              illegal,
  output logic              timeout,
  output logic [1:0]        dbg_state
);

  // Bus handshake: dmem_req rises with we/addr/wdata already valid and all four hold
  // steady until the single-cycle dmem_ack (or the timeout abort); ack seen outside REQ is dropped.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q;
  logic              req_q;
  logic              we_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [DWIDTH-1:0] rdata_q;
  logic              misalign_q;
  logic              illegal_q;
  logic              timeout_q;
  logic [7:0]        cnt_q;

  logic op;
  logic both_op;
  logic unaligned;
  logic good_req;

  assign op        = memrdin | memwrin;
  assign both_op   = memrdin & memwrin;
  assign unaligned = (addrin[1:0] != 2'b00);
  assign good_req  = op & ~both_op & ~unaligned;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (good_req) begin
            addr_q  <= addrin;
            wdata_q <= wdatain;
            we_q    <= memwrin;
            req_q   <= 1'b1;
            cnt_q   <= 8'd0;
            state_q <= REQ;
          end else begin
            // Illegal takes priority: a both-high op never reports misalign.
            illegal_q  <= both_op;
            misalign_q <= op & ~both_op & unaligned;
          end
        end
        REQ: begin
          if (dmem_ack) begin
            req_q   <= 1'b0;
            state_q <= DONE;
            if (!we_q) rdata_q <= dmem_rdata;
          end else if (cnt_q == CNT_LAST) begin
            req_q     <= 1'b0;
            timeout_q <= 1'b1;
            rdata_q   <= '0;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        // The op still sitting on the inputs is the one just finished, so it is ignored here.
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall      = ((state_q == IDLE) && good_req) || (state_q == REQ);
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign rdataout   = rdata_q;
  assign misalign   = misalign_q;
  assign illegal    = illegal_q;
  assign timeout    = timeout_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: inputs change 1ns after posedge, outputs checked at negedge.
module tb_mem_access_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic          clk;
  logic          rst_n;
  logic          memrdin;
  logic          memwrin;
  logic [AW-1:0] addrin;
  logic [DW-1:0] wdatain;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ack;
  logic [DW-1:0] dmem_rdata;
  logic          stall;
  logic [DW-1:0] rdataout;
  logic          misalign;
  logic          illegal;
  logic          timeout;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int req_starts = 0;
  logic req_prev = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_v;

  mem_access_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .memrdin(memrdin), .memwrin(memwrin),
    .addrin(addrin), .wdatain(wdatain), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall(stall), .rdataout(rdataout),
    .misalign(misalign), .illegal(illegal), .timeout(timeout), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // counts bus transactions by rising edge of dmem_req
  always @(posedge clk) begin
    if (dmem_req && !req_prev) req_starts <= req_starts + 1;
    req_prev <= dmem_req;
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    memrdin = rd;
    memwrin = wr;
    addrin  = a;
    wdatain = wd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if ({dmem_req, dmem_we, stall, misalign, illegal, timeout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000000",
               {dmem_req, dmem_we, stall, misalign, illegal, timeout});
    end
    checks++;
    if ({dmem_addr, dmem_wdata, rdataout} !== {AW'(0), DW'(0), DW'(0)}) begin
      errors++;
      $display("FAIL reset_data got %h %h %h exp 0", dmem_addr, dmem_wdata, rdataout);
    end
    checks++;
    if (dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d exp %0d", dbg_state, S_IDLE);
    end
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    drive(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    checks++;
    if ({stall, dmem_req} !== 2'b10) begin
      errors++;
      $display("FAIL t1_c0 stall/req got %b exp 10", {stall, dmem_req});
    end
    next_cycle();
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({dmem_req, dmem_we, stall, dmem_addr} !== {3'b101, 32'h10}) begin
      errors++;
      $display("FAIL t1_c1 req/we/stall/addr got %b %h exp 101 00000010",
               {dmem_req, dmem_we, stall}, dmem_addr);
    end
    next_cycle();
    dmem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({dmem_req, stall, dbg_state} !== {2'b00, S_DONE}) begin
      errors++;
      $display("FAIL t1_c2 req/stall/state got %b exp 0010", {dmem_req, stall, dbg_state});
    end
    checks++;
    if (rdataout !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL t1_rdata got %h exp deadbeef", rdataout);
    end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if ({dbg_state, stall} !== {S_IDLE, 1'b0}) begin
      errors++;
      $display("FAIL t1_c3 state/stall got %b exp 000", {dbg_state, stall});
    end
  endtask

  task automatic test_store();
    int stall_cnt;
    stall_cnt = 0;
    next_cycle();
    drive(1'b0, 1'b1, 32'h24, 32'h12345678);
    @(negedge clk);
    if (stall) stall_cnt++;
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      dmem_ack = (c == 3);
      dmem_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      if (stall) stall_cnt++;
      checks++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {2'b11, 32'h24, 32'h12345678}) begin
        errors++;
        $display("FAIL t2_bus_c%0d got %b %h %h exp 11 00000024 12345678",
                 c, {dmem_req, dmem_we}, dmem_addr, dmem_wdata);
      end
    end
    next_cycle();
    dmem_ack = 1'b0;
    @(negedge clk);
    if (stall) stall_cnt++;
    checks++;
    if ({dmem_req, dbg_state} !== {1'b0, S_DONE}) begin
      errors++;
      $display("FAIL t2_done req/state got %b exp 010", {dmem_req, dbg_state});
    end
    checks++;
    if (stall_cnt !== 4) begin
      errors++;
      $display("FAIL t2_stall_cycles got %0d exp 4", stall_cnt);
    end
    checks++;
    if (rdataout !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL t2_rdata_kept got %h exp deadbeef", rdataout);
    end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_misalign_illegal();
    int starts0;
    starts0 = req_starts;
    next_cycle();
    drive(1'b1, 1'b0, 32'h13, 32'h0);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL t3_mis_stall got %b exp 0", stall);
    end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if ({misalign, illegal, dmem_req, dbg_state} !== {3'b100, S_IDLE}) begin
      errors++;
      $display("FAIL t3_mis_pulse got %b exp 10000", {misalign, illegal, dmem_req, dbg_state});
    end
    next_cycle();
    drive(1'b1, 1'b1, 32'h13, 32'h0);
    @(negedge clk);
    checks++;
    if ({misalign, stall} !== 2'b00) begin
      errors++;
      $display("FAIL t3_mis_clear got %b exp 00", {misalign, stall});
    end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if ({illegal, misalign, dmem_req} !== 3'b100) begin
      errors++;
      $display("FAIL t3_ill_pulse got %b exp 100", {illegal, misalign, dmem_req});
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({illegal, req_starts - starts0, rdataout} !== {1'b0, 32'd0, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL t3_after got ill=%b starts=%0d rdata=%h exp 0 0 deadbeef",
               illegal, req_starts - starts0, rdataout);
    end
  endtask

  task automatic test_timeout();
    next_cycle();
    drive(1'b1, 1'b0, 32'h40, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      @(negedge clk);
      checks++;
      if ({dmem_req, stall, timeout} !== 3'b110) begin
        errors++;
        $display("FAIL t4_req_c%0d got %b exp 110", c, {dmem_req, stall, timeout});
      end
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({dmem_req, timeout, stall, dbg_state} !== {3'b010, S_DONE}) begin
      errors++;
      $display("FAIL t4_abort got %b exp 01010", {dmem_req, timeout, stall, dbg_state});
    end
    checks++;
    if (rdataout !== 32'h0) begin
      errors++;
      $display("FAIL t4_rdata got %h exp 0", rdataout);
    end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if ({timeout, dbg_state} !== {1'b0, S_IDLE}) begin
      errors++;
      $display("FAIL t4_idle got %b exp 000", {timeout, dbg_state});
    end
  endtask

  task automatic test_reset_mid_req();
    // seed rdataout with a value so the reset clearing it is visible
    next_cycle();
    drive(1'b1, 1'b0, 32'h80, 32'h0);
    next_cycle();
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    next_cycle();
    dmem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (rdataout !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL t5_seed got %h exp cafef00d", rdataout);
    end
    next_cycle();
    drive(1'b1, 1'b0, 32'h84, 32'hFFFF0000);
    next_cycle();
    @(negedge clk);
    checks++;
    if (dbg_state !== S_REQ) begin
      errors++;
      $display("FAIL t5_in_req got %0d exp %0d", dbg_state, S_REQ);
    end
    next_cycle();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h11111111;
    next_cycle();
    rst_n = 1'b1;
    dmem_rdata = 32'h55555555;
    @(negedge clk);
    checks++;
    if ({dbg_state, dmem_req, dmem_we, stall, dmem_addr, rdataout} !==
        {S_IDLE, 3'b000, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL t5_after_rst got st=%0d req=%b addr=%h rdata=%h exp 0 0 0 0",
               dbg_state, dmem_req, dmem_addr, rdataout);
    end
    next_cycle();
    dmem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({dbg_state, dmem_req, rdataout} !== {S_IDLE, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL t5_late_ack got st=%0d req=%b rdata=%h exp 0 0 0",
               dbg_state, dmem_req, rdataout);
    end
  endtask

  task automatic test_back_to_back();
    int starts0;
    starts0 = req_starts;
    exp_q.push_back(32'hA5A50001);
    exp_q.push_back(32'h5A5A0002);
    for (int op = 0; op < 2; op++) begin
      next_cycle();
      drive(1'b1, 1'b0, AW'(op * 4), 32'h0);
      @(negedge clk);
      checks++;
      if ({dbg_state, stall, dmem_req} !== {S_IDLE, 2'b10}) begin
        errors++;
        $display("FAIL t6_start%0d got %b exp 0010", op, {dbg_state, stall, dmem_req});
      end
      next_cycle();
      dmem_ack = 1'b1;
      dmem_rdata = (op == 0) ? 32'hA5A50001 : 32'h5A5A0002;
      @(negedge clk);
      checks++;
      if ({dmem_req, dmem_addr} !== {1'b1, AW'(op * 4)}) begin
        errors++;
        $display("FAIL t6_req%0d got %b %h exp 1 %h", op, dmem_req, dmem_addr, op * 4);
      end
      next_cycle();
      dmem_ack = 1'b0;
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if ({dbg_state, rdataout} !== {S_DONE, exp_v}) begin
        errors++;
        $display("FAIL t6_done%0d got st=%0d rdata=%h exp %0d %h",
                 op, dbg_state, rdataout, S_DONE, exp_v);
      end
    end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if ((req_starts - starts0) !== 2) begin
      errors++;
      $display("FAIL t6_access_count got %0d exp 2", req_starts - starts0);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_misalign_illegal();
    test_timeout();
    test_reset_mid_req();
    test_back_to_back();
    next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
